shmemif_arb: RTL and testbench
==============================

// Module: shmemif_arb
// PURPOSE
//  N-port shared single-port-memory interface; next generation of the round-robin shmemif.
//  Adds a request/grant handshake, bounded burst ownership and configurable memory read latency.
//  Read data is returned with a per-port valid strobe.
//  Sits between NB_PORTS processing clients and one physical synchronous RAM.
// PARAMETERS
//  NB_PORTS          4   number of client ports (>=2)
//  LOG2_NB_PORTS     2   clog2(NB_PORTS)
//  ADDR_WIDTH        12  memory address width
//  DATA_WIDTH        32  memory data width
//  MEM_READ_LATENCY  1   cycles from mem_en/mem_addr to valid mem_dataout (>=1)
//  MAX_BURST         4   max consecutive accepts by one port before forced rotation (>=1)
//  LOG2_MAX_BURST    2   clog2(MAX_BURST), min 1
// PORTS
//  clk            in   1              clock, all logic on rising edge
//  srst           in   1              synchronous reset, active high
//  shmem_request  in   NB_PORTS       per-port access request, held until granted
//  shmem_wren     in   NB_PORTS       1=write, 0=read; qualifies request
//  shmem_addr     in   NB*ADDR_WIDTH  packed per-port address, port i at [(i+1)*AW-1:i*AW]
//  shmem_datain   in   NB*DATA_WIDTH  packed per-port write data
//  shmem_grant    out  NB_PORTS       one-hot accept; request&grant = transfer this cycle
//  shmem_dataout  out  NB*DATA_WIDTH  mem_dataout broadcast to every port slice
//  shmem_rvalid   out  NB_PORTS       one-hot read-data valid for the owning port
//  mem_en         out  1              registered memory access enable
//  mem_wren       out  1              registered write enable
//  mem_addr       out  ADDR_WIDTH     registered address
//  mem_datain     out  DATA_WIDTH     registered write data
//  mem_dataout    in   DATA_WIDTH     memory read data
// BEHAVIOUR
//  Reset (srst=1 at edge): mem_en/mem_wren/mem_addr/mem_datain=0, shmem_rvalid=0,
//   rr pointer=NB_PORTS-1 (port 0 wins first), owner invalid, burst count=0,
//   read pipeline flushed. shmem_grant forced 0 while srst=1.
//  Arbitration (combinational from regs + request):
//   - owner valid, owner still requesting, burst count<MAX_BURST: grant owner.
//   - else: first requesting port scanning ptr+1, ptr+2, ... mod NB_PORTS.
//   - no request: grant=0, state unchanged except owner cleared.
//  On accept of port p: ptr<=p; owner<=p. Burst count <=1 if owner changed, else count+1.
//   Count saturates at MAX_BURST; at saturation the next grant goes to another requester if any.
//   If p is the sole requester it is re-granted and count restarts at 1.
//  Memory issue: the edge after accept registers mem_en=1, wren/addr/datain of p.
//   The next cycle without accept registers mem_en=0, mem_wren=0; addr/datain hold.
//  Read return: accepted read pushes {1,p} into a shift pipe of depth MEM_READ_LATENCY+1.
//   shmem_rvalid[p]=1 exactly MEM_READ_LATENCY+1 cycles after the accept cycle.
//   Writes push {0,x}. Back-to-back reads give back-to-back rvalid, order preserved.
//  Throughput: one access per cycle, no bubbles between different ports.
//  Reset mid-operation: in-flight reads are dropped, never signalled.
//  NB_PORTS not a power of two: index scan wraps at NB_PORTS; unused pointer codes are unreachable.
// CONFIGURATION
//  SHMEMIF_ARB_PRIORITY_EN defined:
//   - adds input shmem_priority[NB_PORTS].
//   - requesting ports with priority=1 form the high class, which pre-empts the low class
//     after the owner's current accept. A burst owner in the low class loses ownership.
//   - round robin applies within each class using the shared pointer.
//  Undefined: no port; pure round robin with burst as above.
// TESTING
//  1 reset: srst=1 for 2 cycles with all requests=1 -> grant=0, mem_en=0, rvalid=0; first grant=0001
//  2 all 4 ports read held, MAX_BURST=4 -> port0 accepted 4 consecutive cycles, then port1 x4,
//    rvalid mirrors the same order 2 cycles later (latency 1)
//  3 ports1,3 one read each, same cycle, ptr=0 -> grant 0010 then 1000;
//    mem_addr sequence follows; rvalid 0010 then 1000
//  4 port2 write 0xDEADBEEF @0x0A5, then read @0x0A5 -> mem_wren=1 then 0;
//    shmem_dataout slice2=0xDEADBEEF with rvalid[2]
//  5 MEM_READ_LATENCY=3, srst pulsed 2 cycles after read accept -> that rvalid never asserts
//  6 PRIORITY_EN: port0 bursting low class, port3 raises priority -> next grant 1000, port0 resumes after

Source files
------------

// File: rtl/shmemif_arb.sv
// Round-robin shared single-port-memory arbiter with burst ownership and a latency-matched read-valid pipe.
// Optional build macro SHMEMIF_ARB_PRIORITY_EN adds a two-class priority input.
module shmemif_arb #(
  parameter int unsigned NB_PORTS         = 4,
  parameter int unsigned LOG2_NB_PORTS    = 2,
  parameter int unsigned ADDR_WIDTH       = 12,
  parameter int unsigned DATA_WIDTH       = 32,
  parameter int unsigned MEM_READ_LATENCY = 1,
  parameter int unsigned MAX_BURST        = 4,
  parameter int unsigned LOG2_MAX_BURST   = 2
) (
  input  logic                           clk,
  input  logic                           srst,
  input  logic [NB_PORTS-1:0]            shmem_request,
  input  logic [NB_PORTS-1:0]            shmem_wren,
  input  logic [NB_PORTS*ADDR_WIDTH-1:0] shmem_addr,
  input  logic [NB_PORTS*DATA_WIDTH-1:0] shmem_datain,
`ifdef SHMEMIF_ARB_PRIORITY_EN
  input  logic [NB_PORTS-1:0]            shmem_priority,
`endif
  output logic [NB_PORTS-1:0]            shmem_grant,
  output logic [NB_PORTS*DATA_WIDTH-1:0] shmem_dataout,
  output logic [NB_PORTS-1:0]            shmem_rvalid,
  output logic                           mem_en,
  output logic                           mem_wren,
  output logic [ADDR_WIDTH-1:0]          mem_addr,
  output logic [DATA_WIDTH-1:0]          mem_datain,
  input  logic [DATA_WIDTH-1:0]          mem_dataout
);

  localparam int unsigned CNT_W  = LOG2_MAX_BURST + 1;
  localparam int unsigned PIPE_D = MEM_READ_LATENCY + 1;

  logic [LOG2_NB_PORTS-1:0] ptr;
  logic [LOG2_NB_PORTS-1:0] owner;
  logic                     owner_vld;
  logic [CNT_W-1:0]         cnt;
  logic [NB_PORTS-1:0]      rd_pipe [PIPE_D];

  logic [NB_PORTS-1:0]      cand;
  logic                     owner_class_ok;
  logic [LOG2_NB_PORTS-1:0] scan_sel;
  logic [LOG2_NB_PORTS-1:0] sel;
  logic                     found;
  logic                     keep_owner;
  logic                     accept;
  int unsigned              idx;

  // Candidate set: high class pre-empts low class when any high request is present
`ifdef SHMEMIF_ARB_PRIORITY_EN
  logic [NB_PORTS-1:0] hi_req;
  assign hi_req = shmem_request & shmem_priority;
  always_comb begin
    cand           = (|hi_req) ? hi_req : shmem_request;
    owner_class_ok = ~(|hi_req) | shmem_priority[owner];
  end
`else
  always_comb begin
    cand           = shmem_request;
    owner_class_ok = 1'b1;
  end
`endif

  // Round-robin scan starting just after the pointer, wrapping at NB_PORTS
  always_comb begin
    found    = 1'b0;
    scan_sel = '0;
    idx      = 0;
    for (int unsigned i = 1; i <= NB_PORTS; i++) begin
      idx = (32'(ptr) + i) % NB_PORTS;
      if (!found && cand[LOG2_NB_PORTS'(idx)]) begin
        found    = 1'b1;
        scan_sel = LOG2_NB_PORTS'(idx);
      end
    end
  end

  always_comb begin
    keep_owner  = owner_vld && shmem_request[owner] && (cnt < CNT_W'(MAX_BURST)) && owner_class_ok;
    sel         = keep_owner ? owner : scan_sel;
    accept      = !srst && found;
    shmem_grant = accept ? (NB_PORTS'(1) << sel) : '0;
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      ptr        <= LOG2_NB_PORTS'(NB_PORTS - 1);
      owner      <= '0;
      owner_vld  <= 1'b0;
      cnt        <= '0;
      mem_en     <= 1'b0;
      mem_wren   <= 1'b0;
      mem_addr   <= '0;
      mem_datain <= '0;
      for (int unsigned k = 0; k < PIPE_D; k++) rd_pipe[k] <= '0;
    end else begin
      if (accept) begin
        ptr        <= sel;
        owner      <= sel;
        owner_vld  <= 1'b1;
        cnt        <= (owner_vld && owner == sel && cnt < CNT_W'(MAX_BURST)) ? cnt + CNT_W'(1) : CNT_W'(1);
        mem_en     <= 1'b1;
        mem_wren   <= shmem_wren[sel];
        mem_addr   <= shmem_addr[sel*ADDR_WIDTH +: ADDR_WIDTH];
        mem_datain <= shmem_datain[sel*DATA_WIDTH +: DATA_WIDTH];
      end else begin
        owner_vld  <= 1'b0;
        mem_en     <= 1'b0;
        mem_wren   <= 1'b0;
      end
      // One-hot read tag travels alongside the memory access
      rd_pipe[0] <= (accept && !shmem_wren[sel]) ? (NB_PORTS'(1) << sel) : '0;
      for (int unsigned k = 1; k < PIPE_D; k++) rd_pipe[k] <= rd_pipe[k-1];
    end
  end

  assign shmem_rvalid  = rd_pipe[PIPE_D-1];
  assign shmem_dataout = {NB_PORTS{mem_dataout}};

endmodule

// File: tb/tb_shmemif_arb.sv
// Directed bench for shmemif_arb: latency-1 instance with a RAM model plus a latency-3 instance for reset flush.
module tb_shmemif_arb;

  localparam int unsigned NB = 4;
  localparam int unsigned AW = 12;
  localparam int unsigned DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              srst;
  logic [NB-1:0]     req, wren, gnt, rvalid;
  logic [NB*AW-1:0]  addr;
  logic [NB*DW-1:0]  din, dout;
  logic              mem_en, mem_wren;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_datain, mem_dataout;
`ifdef SHMEMIF_ARB_PRIORITY_EN
  logic [NB-1:0]     prio;
`endif

  logic              srst_b;
  logic [NB-1:0]     req_b, gnt_b, rvalid_b;
  logic [NB*DW-1:0]  dout_b;
  logic              en_b, wren_b;
  logic [AW-1:0]     addr_b;
  logic [DW-1:0]     din_b;

  shmemif_arb #(.MEM_READ_LATENCY(1)) u_dut (
    .clk(clk), .srst(srst),
    .shmem_request(req), .shmem_wren(wren), .shmem_addr(addr), .shmem_datain(din),
`ifdef SHMEMIF_ARB_PRIORITY_EN
    .shmem_priority(prio),
`endif
    .shmem_grant(gnt), .shmem_dataout(dout), .shmem_rvalid(rvalid),
    .mem_en(mem_en), .mem_wren(mem_wren), .mem_addr(mem_addr), .mem_datain(mem_datain),
    .mem_dataout(mem_dataout)
  );

  shmemif_arb #(.MEM_READ_LATENCY(3)) u_dut_lat3 (
    .clk(clk), .srst(srst_b),
    .shmem_request(req_b), .shmem_wren(4'h0), .shmem_addr({(NB*AW){1'b0}}), .shmem_datain({(NB*DW){1'b0}}),
`ifdef SHMEMIF_ARB_PRIORITY_EN
    .shmem_priority(4'h0),
`endif
    .shmem_grant(gnt_b), .shmem_dataout(dout_b), .shmem_rvalid(rvalid_b),
    .mem_en(en_b), .mem_wren(wren_b), .mem_addr(addr_b), .mem_datain(din_b),
    .mem_dataout(32'h0)
  );

  // Synchronous RAM, one-cycle read; unwritten words read back as a tag of their address
  logic [DW-1:0] mem [4096];
  logic          wr_flag [4096];
  always @(posedge clk) begin
    if (srst) begin
      for (int i = 0; i < 4096; i++) wr_flag[i] <= 1'b0;
    end else if (mem_en) begin
      if (mem_wren) begin
        mem[mem_addr]     <= mem_datain;
        wr_flag[mem_addr] <= 1'b1;
      end else begin
        mem_dataout <= wr_flag[mem_addr] ? mem[mem_addr] : {20'hA5A50, mem_addr};
      end
    end
  end

  int n_chk = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NB-1:0] oh(input int p);
    return (p < 0) ? 4'h0 : 4'(1 << p);
  endfunction

  int ep [12] = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, -1, -1};
  int pm1, pm2;

  initial begin
    srst = 1'b1; req = 4'hF; wren = 4'h0; din = '0; addr = '0;
    srst_b = 1'b1; req_b = 4'h0;
`ifdef SHMEMIF_ARB_PRIORITY_EN
    prio = 4'h0;
`endif
    for (int p = 0; p < NB; p++) addr[p*AW +: AW] = 12'(256 + p);

    // reset with all requests high
    cyc(); #1;
    check("rst_gnt_a", 64'(gnt), 64'h0);
    cyc(); #1;
    check("rst_gnt_b", 64'(gnt), 64'h0);
    check("rst_mem_en", 64'(mem_en), 64'h0);
    check("rst_rvalid", 64'(rvalid), 64'h0);

    // all four ports reading: port0 x4, port1 x4, port2 x2, then requests drop
    for (int k = 0; k < 12; k++) begin
      if (k > 0) cyc();
      if (k == 0) srst = 1'b0;
      if (k == 10) req = 4'h0;
      #1;
      check($sformatf("burst_gnt[%0d]", k), 64'(gnt), 64'(oh(ep[k])));
      pm1 = (k >= 1) ? ep[k-1] : -1;
      pm2 = (k >= 2) ? ep[k-2] : -1;
      check($sformatf("burst_en[%0d]", k), 64'(mem_en), 64'(pm1 >= 0));
      if (pm1 >= 0) check($sformatf("burst_addr[%0d]", k), 64'(mem_addr), 64'(256 + pm1));
      check($sformatf("burst_rv[%0d]", k), 64'(rvalid), 64'(oh(pm2)));
      if (pm2 >= 0) check($sformatf("burst_data[%0d]", k), 64'(dout[pm2*DW +: DW]), 64'({20'hA5A50, 12'(256 + pm2)}));
    end

    // move the pointer to port 0, then drain
    cyc(); req = 4'b0001; #1;
    check("ptr0_gnt", 64'(gnt), 64'h1);
    cyc(); req = 4'h0;
    cyc(); cyc();

    // ports 1 and 3 request together, pointer at 0
    cyc(); req = 4'b1010; addr[1*AW +: AW] = 12'h011; addr[3*AW +: AW] = 12'h033; #1;
    check("rr_gnt1", 64'(gnt), 64'h2);
    check("rr_rv0", 64'(rvalid), 64'h0);
    cyc(); req = 4'b1000; #1;
    check("rr_gnt3", 64'(gnt), 64'h8);
    check("rr_addr1", 64'(mem_addr), 64'h011);
    check("rr_rv1", 64'(rvalid), 64'h0);
    cyc(); req = 4'h0; #1;
    check("rr_gnt_idle", 64'(gnt), 64'h0);
    check("rr_addr3", 64'(mem_addr), 64'h033);
    check("rr_rv_p1", 64'(rvalid), 64'h2);
    cyc(); #1;
    check("rr_rv_p3", 64'(rvalid), 64'h8);
    check("rr_en_off", 64'(mem_en), 64'h0);
    cyc(); #1;
    check("rr_rv_done", 64'(rvalid), 64'h0);

    // port 2 write then read-back of the same address
    cyc(); req = 4'b0100; wren = 4'b0100; addr[2*AW +: AW] = 12'h0A5; din[2*DW +: DW] = 32'hDEADBEEF; #1;
    check("wr_gnt", 64'(gnt), 64'h4);
    cyc(); wren = 4'h0; #1;
    check("rd_gnt", 64'(gnt), 64'h4);
    check("wr_mem_wren", 64'(mem_wren), 64'h1);
    check("wr_mem_addr", 64'(mem_addr), 64'h0A5);
    check("wr_mem_din", 64'(mem_datain), 64'hDEADBEEF);
    cyc(); req = 4'h0; #1;
    check("rd_mem_wren", 64'(mem_wren), 64'h0);
    check("rd_mem_en", 64'(mem_en), 64'h1);
    check("wr_no_rv", 64'(rvalid), 64'h0);
    cyc(); #1;
    check("rd_rv", 64'(rvalid), 64'h4);
    check("rd_data", 64'(dout[2*DW +: DW]), 64'hDEADBEEF);
    cyc(); #1;
    check("idle_en", 64'(mem_en), 64'h0);
    check("idle_addr_hold", 64'(mem_addr), 64'h0A5);

    // sole requester keeps being granted across burst saturation
    for (int k = 0; k < 6; k++) begin
      cyc(); req = 4'b0010; #1;
      check($sformatf("sole_gnt[%0d]", k), 64'(gnt), 64'h2);
    end
    cyc(); req = 4'h0;

    // latency 3: rvalid exactly four cycles after accept
    cyc(); srst_b = 1'b0; req_b = 4'b0010; #1;
    check("l3_gnt", 64'(gnt_b), 64'h2);
    for (int j = 1; j <= 5; j++) begin
      cyc(); req_b = 4'h0; #1;
      check($sformatf("l3_rv[%0d]", j), 64'(rvalid_b), (j == 4) ? 64'h2 : 64'h0);
    end

    // reset two cycles after a read accept drops that read
    cyc(); req_b = 4'b0010; #1;
    check("l3_abort_gnt", 64'(gnt_b), 64'h2);
    cyc(); req_b = 4'h0;
    cyc(); srst_b = 1'b1;
    for (int j = 3; j <= 6; j++) begin
      cyc(); srst_b = 1'b0; #1;
      check($sformatf("l3_abort_rv[%0d]", j), 64'(rvalid_b), 64'h0);
    end

`ifdef SHMEMIF_ARB_PRIORITY_EN
    // high-priority port 3 pre-empts low-class burst owner port 0
    cyc(); srst = 1'b1; req = 4'h0;
    cyc(); srst = 1'b0; req = 4'b0001; #1;
    check("pri_gnt0a", 64'(gnt), 64'h1);
    cyc(); #1;
    check("pri_gnt0b", 64'(gnt), 64'h1);
    cyc(); req = 4'b1001; prio = 4'b1000; #1;
    check("pri_gnt3", 64'(gnt), 64'h8);
    cyc(); req = 4'b0001; prio = 4'h0; #1;
    check("pri_gnt0c", 64'(gnt), 64'h1);
    cyc(); req = 4'h0;
`endif

    cyc();
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
